// File: rtl/ecc_pkg.sv
// ecc_pkg: shared definitions for the ECC arithmetic core (modmul_serial, modinv).
//   ECC_WIDTH    default operand width of the core
//   SECP256K1_P  field prime of secp256k1
//   mm_state_t   handshake FSM states shared by the serial arithmetic units
//   cnt_width()  width of a signed bit-index counter for a given operand width
package ecc_pkg;

  localparam int ECC_WIDTH = 256;

  localparam logic [ECC_WIDTH-1:0] SECP256K1_P =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mm_state_t;

  // One extra bit above the largest index so that stepping past bit 0 shows up as
  // the sign bit being set.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/modmul_step.sv
// modmul_step: one combinational step of the interleaved modular multiplier.
//   res = (2*acc + abit*b) mod m, reduced by one conditional subtract after the
//   doubling and one after the addition.
// Ports:
//   acc   in  WIDTH+2  running accumulator (< m for in-range operands)
//   abit  in  1        current multiplier bit
//   b     in  WIDTH    multiplicand
//   m     in  WIDTH    modulus
//   res   out WIDTH+2  updated accumulator
module modmul_step #(
  parameter int WIDTH = 256
) (
  input  logic [WIDTH+1:0] acc,
  input  logic             abit,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH+1:0] res
);

  localparam int AW = WIDTH + 2;

  // Single conditional subtract; enough because each input is below 2*m.
  function automatic logic [AW-1:0] cond_sub(input logic [AW-1:0] x, input logic [AW-1:0] mod);
    logic [AW-1:0] r;
    if (x >= mod) begin
      r = x - mod;
    end else begin
      r = x;
    end
    return r;
  endfunction

  logic [AW-1:0] m_ext_s;
  logic [AW-1:0] b_ext_s;
  logic [AW-1:0] dbl_s;
  logic [AW-1:0] dbl_red_s;
  logic [AW-1:0] sum_s;

  // Double, reduce, conditionally add b, reduce.
  always_comb begin
    m_ext_s = {2'b00, m};
    if (abit) begin
      b_ext_s = {2'b00, b};
    end else begin
      b_ext_s = '0;
    end
    dbl_s     = acc << 1'b1;
    dbl_red_s = cond_sub(dbl_s, m_ext_s);
    sum_s     = dbl_red_s + b_ext_s;
    res       = cond_sub(sum_s, m_ext_s);
  end

endmodule

// File: rtl/modmul_serial.sv
// modmul_serial: bit-serial interleaved modular multiplier, c = a * b mod m.
//   a is scanned MSB first; each RUN cycle doubles the accumulator and adds b
//   when the current bit of a is set, reducing mod m after each operation.
//   Same start/ready handshake and operand layout as modinv.
// Configuration:
//   MODMUL_RADIX4_EN  when defined, two multiplier bits are consumed per cycle by
//                     two chained step units (latency WIDTH/2+1 instead of WIDTH+1).
// Ports:
//   clk    in  1      rising-edge clock
//   rst    in  1      asynchronous active-high reset
//   start  in  1      request, accepted only in IDLE or DONE
//   a      in  WIDTH  multiplier (< m)
//   b      in  WIDTH  multiplicand (< m)
//   m      in  WIDTH  modulus (> 1)
//   c      out WIDTH  result, valid while ready=1
//   ready  out 1      result valid, held until the next accepted start
module modmul_serial
  import ecc_pkg::*;
#(
  parameter int WIDTH = ECC_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] c,
  output logic             ready
);

  localparam int AW = WIDTH + 2;
  localparam int CW = cnt_width(WIDTH);
  localparam int IW = CW - 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);
`ifdef MODMUL_RADIX4_EN
  localparam logic [CW-1:0] CNT_STEP = CW'(2);
`else
  localparam logic [CW-1:0] CNT_STEP = CW'(1);
`endif

  mm_state_t        state_r;
  mm_state_t        next_state_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] m_r;
  logic [AW-1:0]    acc_r;
  // Signed bit index: once it steps below zero every bit has been consumed and
  // the next cycle transfers acc to c.
  logic [CW-1:0]    count_r;
  logic [IW-1:0]    idx_hi_s;
  logic [AW-1:0]    step_out_s;
  logic             bits_done_s;

  assign idx_hi_s    = count_r[IW-1:0];
  assign bits_done_s = count_r[CW-1];

`ifdef MODMUL_RADIX4_EN
  logic [IW-1:0] idx_lo_s;
  logic [AW-1:0] mid_s;

  // count stays odd in this mode, so idx_hi_s >= 1 whenever the steps are used.
  assign idx_lo_s = idx_hi_s - {{(IW-1){1'b0}}, 1'b1};

  modmul_step #(.WIDTH(WIDTH)) u_step_hi (
    .acc  (acc_r),
    .abit (a_r[idx_hi_s]),
    .b    (b_r),
    .m    (m_r),
    .res  (mid_s)
  );

  modmul_step #(.WIDTH(WIDTH)) u_step_lo (
    .acc  (mid_s),
    .abit (a_r[idx_lo_s]),
    .b    (b_r),
    .m    (m_r),
    .res  (step_out_s)
  );
`else
  modmul_step #(.WIDTH(WIDTH)) u_step (
    .acc  (acc_r),
    .abit (a_r[idx_hi_s]),
    .b    (b_r),
    .m    (m_r),
    .res  (step_out_s)
  );
`endif

  // Next-state logic of the handshake FSM.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          next_state_s = RUN;
        end else begin
          next_state_s = IDLE;
        end
      end
      RUN: begin
        if (bits_done_s) begin
          next_state_s = DONE;
        end else begin
          next_state_s = RUN;
        end
      end
      DONE: begin
        if (start) begin
          next_state_s = RUN;
        end else begin
          next_state_s = DONE;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State register, operand capture, accumulator iteration and output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      a_r     <= '0;
      b_r     <= '0;
      m_r     <= '0;
      acc_r   <= '0;
      count_r <= '0;
      c       <= '0;
      ready   <= 1'b0;
    end else begin
      state_r <= next_state_s;
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            a_r     <= a;
            b_r     <= b;
            m_r     <= m;
            acc_r   <= '0;
            count_r <= CNT_INIT;
            ready   <= 1'b0;
          end
        end
        RUN: begin
          if (bits_done_s) begin
            c     <= acc_r[WIDTH-1:0];
            ready <= 1'b1;
          end else begin
            acc_r   <= step_out_s;
            count_r <= count_r - CNT_STEP;
          end
        end
        default: begin
          ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_modmul_serial.sv
// tb_modmul_serial: self-checking bench for modmul_serial with a 256-bit
// instance (m = secp256k1 p unless noted) and an 8-bit instance (m = 251).
// Expected results are queued when a start is driven and compared when ready rises.
module tb_modmul_serial;
  import ecc_pkg::*;

  localparam int W = 256;
`ifdef MODMUL_RADIX4_EN
  localparam int LAT  = W / 2 + 1;
  localparam int LAT8 = 8 / 2 + 1;
`else
  localparam int LAT  = W + 1;
  localparam int LAT8 = 8 + 1;
`endif
  localparam int LIMIT = 2 * W + 20;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] m = '0;
  logic [W-1:0] c;
  logic         ready;

  logic         start8 = 1'b0;
  logic [7:0]   a8 = '0;
  logic [7:0]   b8 = '0;
  logic [7:0]   m8 = '0;
  logic [7:0]   c8;
  logic         ready8;

  int nvec = 0;
  int nerr = 0;
  logic [W-1:0] exp_q[$];
  logic [7:0]   exp8_q[$];

  always #5 clk = ~clk;

  modmul_serial #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .m(m), .c(c), .ready(ready)
  );

  modmul_serial #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .m(m8), .c(c8), .ready(ready8)
  );

  function automatic logic [W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic [W-1:0] mm);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    p = p % {{W{1'b0}}, mm};
    return p[W-1:0];
  endfunction

  function automatic logic [W-1:0] rand_below_p();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
    if (r >= SECP256K1_P) r = r - SECP256K1_P;
    return r;
  endfunction

  task automatic launch(input logic [W-1:0] aa, input logic [W-1:0] bb,
                        input logic [W-1:0] mm, input logic [W-1:0] expv);
    @(negedge clk);
    a = aa; b = bb; m = mm; start = 1'b1;
    exp_q.push_back(expv);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Edges after the current one until ready is seen; -1 if it never rises.
  task automatic wait_ready(output int n);
    bit seen;
    seen = 1'b0;
    n = -1;
    for (int i = 1; i <= LIMIT && !seen; i++) begin
      @(posedge clk);
      #1;
      if (ready) begin
        n = i;
        seen = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    logic [W-1:0] e;
    repeat (3) @(posedge clk);
    #1;
    nvec++; if (c !== '0) begin nerr++; $display("FAIL reset_c: got %h need 0", c); end
    nvec++; if (ready !== 1'b0) begin nerr++; $display("FAIL reset_ready: got %b need 0", ready); end
    nvec++; if (c8 !== 8'd0) begin nerr++; $display("FAIL reset_c8: got %h need 0", c8); end
    nvec++; if (ready8 !== 1'b0) begin nerr++; $display("FAIL reset_ready8: got %b need 0", ready8); end
    @(negedge clk);
    rst = 1'b0;
    e = '0;
  endtask

  task automatic test_basic();
    int n;
    logic [W-1:0] e;
    launch(256'd2, 256'd3, SECP256K1_P, 256'd6);
    wait_ready(n);
    nvec++; if (n != LAT) begin nerr++; $display("FAIL basic_latency: got %0d need %0d", n, LAT); end
    e = exp_q.pop_front();
    nvec++; if (c !== e) begin nerr++; $display("FAIL basic_2x3: got %h need %h", c, e); end
  endtask

  task automatic test_corner();
    int n;
    logic [W-1:0] e;
    logic [W-1:0] pm1;
    logic [W-1:0] pm2;
    pm1 = SECP256K1_P - 256'd1;
    pm2 = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2D;
    launch(pm1, pm1, SECP256K1_P, 256'd1);
    wait_ready(n);
    nvec++; if (n != LAT) begin nerr++; $display("FAIL corner1_latency: got %0d need %0d", n, LAT); end
    e = exp_q.pop_front();
    nvec++; if (c !== e) begin nerr++; $display("FAIL corner_pm1_sq: got %h need %h", c, e); end
    launch(pm1, 256'd2, SECP256K1_P, pm2);
    wait_ready(n);
    nvec++; if (n != LAT) begin nerr++; $display("FAIL corner2_latency: got %0d need %0d", n, LAT); end
    e = exp_q.pop_front();
    nvec++; if (c !== e) begin nerr++; $display("FAIL corner_pm1_x2: got %h need %h", c, e); end
  endtask

  task automatic test_roundtrip();
    int n;
    logic [W-1:0] e;
    launch(256'h8a85638b56a4e194b87704f6f4fdf8831bcc4d8762d627e9bc40b0d427fc13c9,
           256'hacd11bb4ed4278829d0c01d61e87bcca10c19e3cabcb8545370e8bb49b57f13a,
           SECP256K1_P,
           256'hfed5b7e864ae24ed502e69af8acfe4c97190cbac30c2728c0d87afc60791219a);
    wait_ready(n);
    nvec++; if (n != LAT) begin nerr++; $display("FAIL roundtrip_latency: got %0d need %0d", n, LAT); end
    e = exp_q.pop_front();
    nvec++; if (c !== e) begin nerr++; $display("FAIL roundtrip: got %h need %h", c, e); end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [W-1:0] e;
    logic [W-1:0] old_c;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    rb = rand_below_p();
    launch(256'd0, rb, SECP256K1_P, 256'd0);
    wait_ready(n);
    nvec++; if (n != LAT) begin nerr++; $display("FAIL zero_latency: got %0d need %0d", n, LAT); end
    e = exp_q.pop_front();
    nvec++; if (c !== e) begin nerr++; $display("FAIL zero_a: got %h need %h", c, e); end
    // Second start issued in the first cycle that shows ready.
    old_c = e;
    ra = rand_below_p();
    rb = rand_below_p();
    launch(ra, rb, SECP256K1_P, model(ra, rb, SECP256K1_P));
    nvec++; if (ready !== 1'b0) begin nerr++; $display("FAIL b2b_ready_drop: got %b need 0", ready); end
    nvec++; if (c !== old_c) begin nerr++; $display("FAIL b2b_c_held: got %h need %h", c, old_c); end
    wait_ready(n);
    nvec++; if (n != LAT) begin nerr++; $display("FAIL b2b_latency: got %0d need %0d", n, LAT); end
    e = exp_q.pop_front();
    nvec++; if (c !== e) begin nerr++; $display("FAIL b2b_random: got %h need %h", c, e); end
  endtask

  task automatic test_start_mid_run();
    int n;
    logic [W-1:0] e;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    ra = rand_below_p();
    rb = rand_below_p();
    launch(ra, rb, SECP256K1_P, model(ra, rb, SECP256K1_P));
    repeat (10) @(posedge clk);
    @(negedge clk);
    a = rand_below_p(); b = rand_below_p(); m = 256'd97; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_ready(n);
    if (n > 0) n = n + 11;
    nvec++; if (n != LAT) begin nerr++; $display("FAIL midstart_latency: got %0d need %0d", n, LAT); end
    e = exp_q.pop_front();
    nvec++; if (c !== e) begin nerr++; $display("FAIL midstart_result: got %h need %h", c, e); end
  endtask

  task automatic test_rst_mid_run();
    int n;
    logic [W-1:0] e;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    ra = rand_below_p();
    rb = rand_below_p();
    launch(ra, rb, SECP256K1_P, model(ra, rb, SECP256K1_P));
    e = exp_q.pop_front();  // aborted run produces nothing
    repeat (30) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    nvec++; if (c !== '0) begin nerr++; $display("FAIL rst_mid_c: got %h need 0", c); end
    nvec++; if (ready !== 1'b0) begin nerr++; $display("FAIL rst_mid_ready: got %b need 0", ready); end
    @(negedge clk);
    rst = 1'b0;
    repeat (LAT + 5) @(posedge clk);
    #1;
    nvec++; if (ready !== 1'b0) begin nerr++; $display("FAIL rst_no_result: got %b need 0", ready); end
    ra = rand_below_p();
    rb = rand_below_p();
    launch(ra, rb, SECP256K1_P, model(ra, rb, SECP256K1_P));
    wait_ready(n);
    nvec++; if (n != LAT) begin nerr++; $display("FAIL rst_fresh_latency: got %0d need %0d", n, LAT); end
    e = exp_q.pop_front();
    nvec++; if (c8 === c8 && c !== e) begin nerr++; $display("FAIL rst_fresh_result: got %h need %h", c, e); end
  endtask

  task automatic test_width8();
    logic [7:0] e;
    logic [7:0] va[2];
    logic [7:0] vb[2];
    logic [7:0] vc[2];
    int n;
    bit seen;
    va[0] = 8'd200; vb[0] = 8'd100; vc[0] = 8'd171;
    va[1] = 8'd250; vb[1] = 8'd250; vc[1] = 8'd1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      a8 = va[k]; b8 = vb[k]; m8 = 8'd251; start8 = 1'b1;
      exp8_q.push_back(vc[k]);
      @(posedge clk);
      #1;
      start8 = 1'b0;
      n = -1;
      seen = 1'b0;
      for (int i = 1; i <= 64 && !seen; i++) begin
        @(posedge clk);
        #1;
        if (ready8) begin
          n = i;
          seen = 1'b1;
        end
      end
      nvec++; if (n != LAT8) begin nerr++; $display("FAIL w8_latency_%0d: got %0d need %0d", k, n, LAT8); end
      e = exp8_q.pop_front();
      nvec++; if (c8 !== e) begin nerr++; $display("FAIL w8_result_%0d: got %0d need %0d", k, c8, e); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corner();
    test_roundtrip();
    test_back_to_back();
    test_start_mid_run();
    test_rst_mid_run();
    test_width8();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
